pulse_acq_sequencer: RTL
========================

# pulse_acq_sequencer

Top-level acquisition controller for the pulse-oximeter datapath. Drives the 2-bit mode control of the data buffer (idle / diagnostic / stream) and runs AFE diagnostics with bounded retries before enabling streaming. Watches the AFE data-ready strobe with a watchdog, counts completed sample sets, and holds SpO2/HR results for the CPU/FIFO side under a valid/ack handshake.

## Interface

Parameters:
- DIAG_TIMEOUT, 1000: cycles allowed in DIAG for a verdict on in_diag_er.
- DRDY_TIMEOUT, 50000: cycles without in_strm_dn in STREAM before re-diagnosis.
- MAX_RETRY, 3: diagnostic failures tolerated before FAULT (range 1..3).
- SETTLE_CYCLES, 4: cycles of mode 2'b00 driven between any two non-idle modes (≥1).

Ports (clock and reset: one clock; reset is asynchronous and active-low):
- clk  in  1  system clock.
- in_reset_n  in  1  asynchronous active-low reset.
- in_start  in  1  one-cycle start/restart request.
- in_stop  in  1  one-cycle stop request.
- out_data_control  out  2  mode to data buffer: 00 idle, 01 diag, 10 stream.
- in_diag_er  in  2  diag verdict from data buffer: 00 pending, 10 pass, 01 fail.
- in_er_data  in  14  AFE diagnostic flag word.
- in_strm_dn  in  1  AFE data-ready strobe.
- in_new_samples  in  1  data buffer "sample set complete" level.
- in_final_comp_complete  in  1  one-cycle result-ready pulse.
- in_spo2, in_hr  in  24 each  computed results.
- out_spo2, out_hr  out  24 each  latched results.
- out_result_valid  out  1  result held; cleared by ack.
- in_result_ack  in  1  consumer accepts result.
- out_overrun  out  1  sticky: result overwritten while valid.
- out_sample_count  out  16  saturating count of sample sets.
- out_state  out  3  current FSM state encoding.
- out_fault  out  1  high in FAULT.
- out_fault_code  out  14  last failing in_er_data; 14'h3FFF for diag timeout.
- out_retry_count  out  2  diag failures since last successful diag or start.

## Operation

- States: IDLE=0, SETTLE=1, DIAG=2, STREAM=3, FAULT=4. A target register selects DIAG or STREAM as SETTLE's exit.
- Reset: state IDLE, all outputs 0, all counters 0.
- IDLE: control 00. in_start → SETTLE (target DIAG); clears sample count, retry count, fault code, overrun.
- SETTLE: control 00 for SETTLE_CYCLES cycles, then enter target.
- DIAG: control 01; timer counts. in_diag_er=10 → SETTLE (target STREAM), retry←0. in_diag_er=01 → latch in_er_data into fault code, retry+1. Timer reaching DIAG_TIMEOUT with 00 → fault code 14'h3FFF, retry+1. After failure: retry<MAX_RETRY → SETTLE (target DIAG); else FAULT.
- STREAM: control 10. Watchdog cleared on each in_strm_dn; reaching DRDY_TIMEOUT → SETTLE (target DIAG), retry unchanged. Rising edge of in_new_samples (registered previous value) increments sample count, saturating at 16'hFFFF; edges outside STREAM ignored.
- FAULT: control 00, out_fault=1. in_start → same actions as start from IDLE, out_fault←0.
- in_stop in any state → IDLE next cycle, control 00; counters and results retained. in_stop wins over simultaneous in_start. in_start in SETTLE/DIAG/STREAM ignored.
- Results (all states): in_final_comp_complete latches in_spo2/in_hr, sets out_result_valid. in_result_ack with valid clears valid. Complete while valid and no ack → overwrite, set out_overrun. Complete and ack same cycle → new data latched, valid stays 1, no overrun.

## Timing

- All outputs registered; out_data_control changes the cycle after the state change.
- start in IDLE → control 01 after exactly 1+SETTLE_CYCLES cycles.
- Diag pass/fail sampled the cycle in_diag_er is nonzero; control returns to 00 the following cycle.
- Watchdog fires on cycle DRDY_TIMEOUT after the last in_strm_dn (count equals parameter).
- Result latched / valid set one cycle after the complete pulse; valid drops the cycle after ack.
- Reset assertion mid-operation forces IDLE and control 00 asynchronously.

## Test plan

- Reset, start, in_diag_er=10 after 5 cycles → control 00×4, 01, then 00×4, 10; state STREAM, retry 0.
- Diag fails with in_er_data=14'h0021 three times (MAX_RETRY=3) → FAULT, out_fault=1, fault code 14'h0021, retry 3; start → DIAG again with retry 0.
- Diag stays 00 for DIAG_TIMEOUT=1000 → fault code 14'h3FFF, retry 1, re-enter DIAG.
- In STREAM, strobes stop for 50000 cycles → SETTLE then DIAG; 10 new_samples rising edges before that → sample count 10.
- Two complete pulses without ack → overrun=1, second values held; complete+ack same cycle → valid stays 1, overrun unchanged.
- Start and stop asserted together in STREAM → IDLE, control 00 next cycle; reset asserted mid-DIAG → all outputs 0 immediately.

Source files
------------

// File: rtl/pulse_acq_sequencer.sv
// pulse_acq_sequencer
// Acquisition controller for the pulse-oximeter datapath. Runs AFE
// diagnostics with bounded retries, then streams while a watchdog checks
// the AFE data-ready strobe. Counts completed sample sets and holds
// SpO2/HR results for the consumer under a valid/ack handshake.
//
// Ports
//   clk, in_reset_n           clock, async active-low reset
//   in_start, in_stop         one-cycle start/restart and stop requests
//   out_data_control[1:0]     buffer mode: 00 idle, 01 diag, 10 stream
//   in_diag_er[1:0]           diag verdict: 00 pending, 10 pass, 01 fail
//   in_er_data[13:0]          AFE diagnostic flag word
//   in_strm_dn                AFE data-ready strobe
//   in_new_samples            sample-set-complete level
//   in_final_comp_complete    result-ready pulse with in_spo2/in_hr
//   out_spo2/out_hr           latched results, out_result_valid/in_result_ack
//   out_overrun               sticky result-overwrite flag
//   out_sample_count          saturating sample-set count
//   out_state, out_fault, out_fault_code, out_retry_count  status
//
// state  | meaning
// IDLE   | buffer idle, waiting for start
// SETTLE | buffer idle for SETTLE_CYCLES before entering the target mode
// DIAG   | diagnostic mode, waiting for a verdict or timeout
// STREAM | streaming, data-ready watchdog running
// FAULT  | retries exhausted, waiting for restart
module pulse_acq_sequencer #(
  parameter int DIAG_TIMEOUT  = 1000,
  parameter int DRDY_TIMEOUT  = 50000,
  parameter int MAX_RETRY     = 3,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        in_reset_n,
  input  logic        in_start,
  input  logic        in_stop,
  output logic [1:0]  out_data_control,
  input  logic [1:0]  in_diag_er,
  input  logic [13:0] in_er_data,
  input  logic        in_strm_dn,
  input  logic        in_new_samples,
  input  logic        in_final_comp_complete,
  input  logic [23:0] in_spo2,
  input  logic [23:0] in_hr,
  output logic [23:0] out_spo2,
  output logic [23:0] out_hr,
  output logic        out_result_valid,
  input  logic        in_result_ack,
  output logic        out_overrun,
  output logic [15:0] out_sample_count,
  output logic [2:0]  out_state,
  output logic        out_fault,
  output logic [13:0] out_fault_code,
  output logic [1:0]  out_retry_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    DIAG   = 3'd2,
    STREAM = 3'd3,
    FAULT  = 3'd4
  } state_t;

  localparam int MAX_A = (DIAG_TIMEOUT > SETTLE_CYCLES) ? DIAG_TIMEOUT : SETTLE_CYCLES;
  localparam int MAX_T = (DRDY_TIMEOUT > MAX_A) ? DRDY_TIMEOUT : MAX_A;
  localparam int TW    = $clog2(MAX_T + 1);

  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] DIAG_LOAD   = TW'(DIAG_TIMEOUT - 1);
  localparam logic [TW-1:0] DRDY_LOAD   = TW'(DRDY_TIMEOUT - 1);
  localparam logic [1:0]    RETRY_LIMIT = 2'(MAX_RETRY);

  state_t        state;
  logic          to_stream;     // SETTLE exit target: 1 = STREAM, 0 = DIAG
  logic [TW-1:0] timer;         // shared down-counter; states never overlap
  logic          new_prev;
  logic          diag_failed;
  logic [13:0]   fail_code;
  logic [1:0]    retry_next;

  // 11 on in_diag_er is not a defined verdict and is treated as pending.
  always_comb begin
    diag_failed = 1'b0;
    fail_code   = 14'h3FFF;
    if (in_diag_er == 2'b01) begin
      diag_failed = 1'b1;
      fail_code   = in_er_data;
    end else if (in_diag_er != 2'b10 && timer == '0) begin
      diag_failed = 1'b1;
    end
    retry_next = out_retry_count + 2'd1;
  end

  assign out_state = state;

  always_ff @(posedge clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state            <= IDLE;
      to_stream        <= 1'b0;
      timer            <= '0;
      new_prev         <= 1'b0;
      out_data_control <= 2'b00;
      out_spo2         <= '0;
      out_hr           <= '0;
      out_result_valid <= 1'b0;
      out_overrun      <= 1'b0;
      out_sample_count <= '0;
      out_fault        <= 1'b0;
      out_fault_code   <= '0;
      out_retry_count  <= '0;
    end else begin
      // Mode output follows the state one cycle later.
      case (state)
        DIAG:    out_data_control <= 2'b01;
        STREAM:  out_data_control <= 2'b10;
        default: out_data_control <= 2'b00;
      endcase

      new_prev <= in_new_samples;
      if (state == STREAM && in_new_samples && !new_prev && out_sample_count != 16'hFFFF)
        out_sample_count <= out_sample_count + 16'd1;

      if (in_final_comp_complete) begin
        out_spo2         <= in_spo2;
        out_hr           <= in_hr;
        out_result_valid <= 1'b1;
        if (out_result_valid && !in_result_ack)
          out_overrun <= 1'b1;
      end else if (in_result_ack) begin
        out_result_valid <= 1'b0;
      end

      if (in_stop) begin
        state     <= IDLE;
        out_fault <= 1'b0;
      end else begin
        case (state)
          IDLE, FAULT: begin
            if (in_start) begin
              state            <= SETTLE;
              to_stream        <= 1'b0;
              timer            <= SETTLE_LOAD;
              out_sample_count <= '0;
              out_retry_count  <= '0;
              out_fault_code   <= '0;
              out_overrun      <= 1'b0;
              out_fault        <= 1'b0;
            end
          end
          SETTLE: begin
            if (timer == '0) begin
              state <= to_stream ? STREAM : DIAG;
              timer <= to_stream ? DRDY_LOAD : DIAG_LOAD;
            end else begin
              timer <= timer - TW'(1);
            end
          end
          DIAG: begin
            if (in_diag_er == 2'b10) begin
              state           <= SETTLE;
              to_stream       <= 1'b1;
              timer           <= SETTLE_LOAD;
              out_retry_count <= '0;
            end else if (diag_failed) begin
              out_fault_code  <= fail_code;
              out_retry_count <= retry_next;
              if (retry_next < RETRY_LIMIT) begin
                state     <= SETTLE;
                to_stream <= 1'b0;
                timer     <= SETTLE_LOAD;
              end else begin
                state     <= FAULT;
                out_fault <= 1'b1;
              end
            end else begin
              timer <= timer - TW'(1);
            end
          end
          STREAM: begin
            if (in_strm_dn) begin
              timer <= DRDY_LOAD;
            end else if (timer == '0) begin
              state     <= SETTLE;
              to_stream <= 1'b0;
              timer     <= SETTLE_LOAD;
            end else begin
              timer <= timer - TW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
